// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared encodings for the UART transmit frame controller:
//                FSM state codes, parity type codes and line-level bit values.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Frame controller state encoding (3-bit)
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line levels for the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Number of DATA cycles tolerated without ser_done before the frame is forced to STOP
    localparam logic [3:0] WD_LIMIT = 4'd8;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : uart_parity_calc
//  Description : Combinational parity generator. Even parity yields the
//                xor-reduction of the data; odd parity yields its inverse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    logic w_xor_red;

    assign w_xor_red = ^data;

    // Select the reduction or its inverse according to the parity type
    always_comb begin
        par_bit = w_xor_red;
        if (par_typ == PAR_ODD) begin
            par_bit = ~w_xor_red;
        end else if (par_typ == PAR_EVEN) begin
            par_bit = w_xor_red;
        end
    end

endmodule : uart_parity_calc
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame_ctrl
//  Description : UART transmit frame controller. Accepts a byte, sequences
//                START / DATA / PARITY / STOP, drives the serializer enable
//                and the shared busy flag, and muxes the TX line.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  tx_out
);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    frame_err_q;
    logic [3:0]              r_wd_cnt;
    logic                    r_par_bit;
    logic                    w_par_bit;

    // Parity is always derived from the shadow copy so mid-frame input changes cannot leak in
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (w_par_bit)
    );

    // Frame sequencer, shadow registers, DATA watchdog and registered parity bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            frame_err_q <= 1'b0;
            r_wd_cnt    <= 4'd0;
            r_par_bit   <= 1'b0;
        end else begin
            // Shadow data is stable from START onward, so the registered copy is settled long before PARITY
            r_par_bit <= w_par_bit;
            case (r_state)
                IDLE: begin
                    if (data_valid) begin
                        data_q    <= p_data;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        r_state   <= START;
                    end
                end
                START: begin
                    r_wd_cnt <= 4'd0;
                    r_state  <= DATA;
                end
                DATA: begin
                    if (ser_done) begin
                        r_state <= par_en_q ? PARITY : STOP;
                    end else if (r_wd_cnt == WD_LIMIT) begin
                        // Ninth DATA cycle without ser_done: close the frame and flag it
                        r_state     <= STOP;
                        frame_err_q <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    r_state <= STOP;
                end
                STOP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Serializer enable: START pre-loads bit0, DATA shifts until the last bit is presented
    always_comb begin
        ser_en = (r_state == START) || ((r_state == DATA) && !ser_done);
        busy   = (r_state != IDLE);
    end

    // TX line is a pure mux of registered sources selected by the registered state
    always_comb begin
        tx_out = STOP_BIT;
        case (r_state)
            IDLE:    tx_out = STOP_BIT;
            START:   tx_out = START_BIT;
            DATA:    tx_out = ser_data;
            PARITY:  tx_out = r_par_bit;
            STOP:    tx_out = STOP_BIT;
            default: tx_out = STOP_BIT;
        endcase
    end

endmodule : uart_tx_frame_ctrl
`default_nettype wire
